// File: rtl/regfile_wr_arbiter.sv
// Round-robin write arbiter for a register bank with a hardware zeroing sweep.
// Register 0 is hardwired zero and is never enabled.
module regfile_wr_arbiter #(
    parameter int NREQ   = 4,
    parameter int DATA_W = 32,
    parameter int ADDR_W = 5
) (
    input  logic                     clk,
    input  logic                     clr_n,
    input  logic [NREQ-1:0]          req_valid,
    input  logic [NREQ*ADDR_W-1:0]   req_addr,
    input  logic [NREQ*DATA_W-1:0]   req_data,
    output logic [NREQ-1:0]          req_ready,
    input  logic                     sweep_start,
    output logic                     sweep_busy,
    output logic                     sweep_done,
    output logic [(2**ADDR_W)-1:0]   wr_en,
    output logic [DATA_W-1:0]        wr_data
);

    localparam int NREG  = 2**ADDR_W;
    localparam int PTR_W = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam logic [ADDR_W-1:0] LAST_IDX = ADDR_W'(NREG - 1);

    typedef enum logic [0:0] {IDLE = 1'b0, SWEEP = 1'b1} state_t;

    function automatic logic [NREG-1:0] onehot(input logic [ADDR_W-1:0] idx);
        logic [NREG-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

    state_t             state_r, state_s;
    logic [PTR_W-1:0]   ptr_r, ptr_s;
    logic [ADDR_W-1:0]  cnt_r, cnt_s;
    logic [NREG-1:0]    wr_en_s;
    logic [DATA_W-1:0]  wr_data_s;
    logic               busy_s, done_s;
    logic [NREQ-1:0]    grant_s;
    logic [PTR_W-1:0]   gnt_idx_s;
    logic               gnt_any_s;
    logic               arb_en_s;
    logic [ADDR_W-1:0]  gnt_addr_s;
    logic [DATA_W-1:0]  gnt_data_s;

    // Round-robin search upward from ptr_r with wrap-around; first valid wins.
    always_comb begin
        logic [PTR_W-1:0] idx_v;
        grant_s   = '0;
        gnt_idx_s = '0;
        gnt_any_s = 1'b0;
        idx_v     = '0;
        for (int j = 0; j < NREQ; j++) begin
            idx_v = PTR_W'((int'(ptr_r) + j) % NREQ);
            if (!gnt_any_s && req_valid[idx_v]) begin
                grant_s[idx_v] = 1'b1;
                gnt_idx_s      = idx_v;
                gnt_any_s      = 1'b1;
            end else begin
                gnt_any_s = gnt_any_s;
            end
        end
    end

    // Grants only in IDLE, never alongside a sweep request, never in reset.
    always_comb begin
        arb_en_s   = (state_r == IDLE) && !sweep_start && clr_n;
        req_ready  = arb_en_s ? grant_s : '0;
        gnt_addr_s = req_addr[int'(gnt_idx_s)*ADDR_W +: ADDR_W];
        gnt_data_s = req_data[int'(gnt_idx_s)*DATA_W +: DATA_W];
    end

    // Next-state and next registered-output computation.
    always_comb begin
        state_s   = state_r;
        ptr_s     = ptr_r;
        cnt_s     = cnt_r;
        wr_en_s   = '0;
        wr_data_s = wr_data;
        busy_s    = 1'b0;
        done_s    = 1'b0;
        case (state_r)
            IDLE: begin
                if (sweep_start) begin
                    state_s   = SWEEP;
                    cnt_s     = ADDR_W'(1);
                    wr_en_s   = onehot(ADDR_W'(1));
                    wr_data_s = '0;
                    busy_s    = 1'b1;
                end else if (gnt_any_s) begin
                    ptr_s     = (gnt_idx_s == PTR_W'(NREQ - 1)) ? '0 : gnt_idx_s + PTR_W'(1);
                    wr_en_s   = (gnt_addr_s == '0) ? '0 : onehot(gnt_addr_s);
                    wr_data_s = gnt_data_s;
                end else begin
                    state_s = IDLE;
                end
            end
            SWEEP: begin
                if (cnt_r == LAST_IDX) begin
                    state_s = IDLE;
                    cnt_s   = '0;
                    done_s  = 1'b1;
                end else begin
                    cnt_s   = cnt_r + ADDR_W'(1);
                    wr_en_s = onehot(cnt_r + ADDR_W'(1));
                    busy_s  = 1'b1;
                end
            end
            default: begin
                state_s = IDLE;
                cnt_s   = '0;
            end
        endcase
    end

    // State and output registers; reset discards any in-flight transfer.
    always_ff @(posedge clk or negedge clr_n) begin
        if (!clr_n) begin
            state_r    <= IDLE;
            ptr_r      <= '0;
            cnt_r      <= '0;
            wr_en      <= '0;
            wr_data    <= '0;
            sweep_busy <= 1'b0;
            sweep_done <= 1'b0;
        end else begin
            state_r    <= state_s;
            ptr_r      <= ptr_s;
            cnt_r      <= cnt_s;
            wr_en      <= wr_en_s;
            wr_data    <= wr_data_s;
            sweep_busy <= busy_s;
            sweep_done <= done_s;
        end
    end

endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// Scoreboard bench for regfile_wr_arbiter: directed cycles push expected outputs,
// a negedge monitor pops and compares them against the DUT.
module tb_regfile_wr_arbiter;

    localparam int NREQ   = 4;
    localparam int DATA_W = 32;
    localparam int ADDR_W = 5;

    logic                   clk = 1'b0;
    logic                   clr_n;
    logic [NREQ-1:0]        req_valid;
    logic [NREQ*ADDR_W-1:0] req_addr;
    logic [NREQ*DATA_W-1:0] req_data;
    logic [NREQ-1:0]        req_ready;
    logic                   sweep_start;
    logic                   sweep_busy;
    logic                   sweep_done;
    logic [31:0]            wr_en;
    logic [DATA_W-1:0]      wr_data;

    always #5 clk = ~clk;

    regfile_wr_arbiter #(.NREQ(NREQ), .DATA_W(DATA_W), .ADDR_W(ADDR_W)) dut (
        .clk(clk), .clr_n(clr_n),
        .req_valid(req_valid), .req_addr(req_addr), .req_data(req_data),
        .req_ready(req_ready),
        .sweep_start(sweep_start), .sweep_busy(sweep_busy), .sweep_done(sweep_done),
        .wr_en(wr_en), .wr_data(wr_data)
    );

    typedef struct packed {
        logic [7:0]  scn;
        logic [3:0]  ready;
        logic [31:0] en;
        logic [31:0] data;
        logic        busy;
        logic        done;
    } exp_t;

    exp_t       exp_q[$];
    int         tests_run    = 0;
    int         tests_failed = 0;
    logic [7:0] scn_r        = 8'd0;
    int         vec_n        = 0;

    localparam logic [31:0] D0 = 32'h1000_0001;
    localparam logic [31:0] D1 = 32'h2000_0002;
    localparam logic [31:0] D2 = 32'h3000_0003;
    localparam logic [31:0] D3 = 32'h4000_0004;
    localparam logic [31:0] DB = 32'hDEAD_BEEF;
    localparam logic [31:0] DA = 32'h0000_00A5;
    localparam logic [31:0] DZ = 32'h0000_1234;
    localparam logic [31:0] DC = 32'hCAFE_0035;
    localparam logic [31:0] DF = 32'h0BAD_F00D;

    function automatic exp_t mk(input logic [3:0] r, input logic [31:0] en,
                                input logic [31:0] d, input logic b, input logic dn);
        exp_t e;
        e.scn = scn_r; e.ready = r; e.en = en; e.data = d; e.busy = b; e.done = dn;
        return e;
    endfunction

    function automatic logic [31:0] bit_at(input int k);
        logic [31:0] one;
        one = 32'd1;
        return one << k;
    endfunction

    // Only called when the preceding cycle makes no transfer.
    task automatic set_req(input int i, input logic [ADDR_W-1:0] a, input logic [DATA_W-1:0] d);
        req_addr[i*ADDR_W +: ADDR_W] = a;
        req_data[i*DATA_W +: DATA_W] = d;
    endtask

    task automatic step(input logic c, input logic s, input logic [3:0] v, input exp_t e);
        @(posedge clk);
        #1;
        clr_n       = c;
        sweep_start = s;
        req_valid   = v;
        exp_q.push_back(e);
    endtask

    // Monitor: compare the DUT outputs against the oldest expected record.
    always @(negedge clk) begin
        exp_t e;
        if (exp_q.size() != 0) begin
            e = exp_q.pop_front();
            tests_run++;
            if (req_ready !== e.ready || wr_en !== e.en || wr_data !== e.data ||
                sweep_busy !== e.busy || sweep_done !== e.done) begin
                tests_failed++;
                $display("FAIL vec%0d scn%0d: got ready=%b wr_en=%h wr_data=%h busy=%b done=%b, want ready=%b wr_en=%h wr_data=%h busy=%b done=%b",
                         vec_n, e.scn, req_ready, wr_en, wr_data, sweep_busy, sweep_done,
                         e.ready, e.en, e.data, e.busy, e.done);
            end
            vec_n++;
        end
    end

    initial begin
        clr_n       = 1'b0;
        sweep_start = 1'b0;
        req_valid   = 4'b0000;
        req_addr    = '0;
        req_data    = '0;

        // Reset: everything zero even with requests pending
        scn_r = 8'd1;
        step(1'b0, 1'b0, 4'b1111, mk(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 4'b1111, mk(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0));

        // All requesters valid: grants 0,1,2,3; writes one cycle later
        scn_r = 8'd2;
        set_req(0, 5'd1, D0); set_req(1, 5'd2, D1); set_req(2, 5'd3, D2); set_req(3, 5'd4, D3);
        step(1'b1, 1'b0, 4'b1111, mk(4'b0001, 32'd0,    32'd0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b1111, mk(4'b0010, bit_at(1), D0,   1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b1111, mk(4'b0100, bit_at(2), D1,   1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b1111, mk(4'b1000, bit_at(3), D2,   1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(4), D3,   1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0,     D3,   1'b0, 1'b0));

        // Requester 2 writes addr 5
        scn_r = 8'd3;
        set_req(2, 5'd5, DB);
        step(1'b1, 1'b0, 4'b0100, mk(4'b0100, 32'd0,     D3, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(5), DB, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0,     DB, 1'b0, 1'b0));

        // Pointer at 3 wraps to requester 0, then moves to 1
        scn_r = 8'd4;
        set_req(0, 5'd9, DA);
        step(1'b1, 1'b0, 4'b0011, mk(4'b0001, 32'd0,     DB, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0011, mk(4'b0010, bit_at(9), DA, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(2), D1, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0,     D1, 1'b0, 1'b0));

        // Write to register 0: accepted, data updates, no enable
        scn_r = 8'd5;
        set_req(3, 5'd0, DZ);
        step(1'b1, 1'b0, 4'b1000, mk(4'b1000, 32'd0, D1, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0, DZ, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0, DZ, 1'b0, 1'b0));

        // Sweep beats a same-cycle request; sweep_start ignored mid-sweep
        scn_r = 8'd6;
        set_req(0, 5'd9, DC);
        step(1'b1, 1'b1, 4'b0001, mk(4'b0000, 32'd0, DZ, 1'b0, 1'b0));
        for (int k = 1; k < 32; k++) begin
            step(1'b1, (k == 5 || k == 31), 4'b0001, mk(4'b0000, bit_at(k), 32'd0, 1'b1, 1'b0));
        end
        step(1'b1, 1'b0, 4'b0001, mk(4'b0001, 32'd0,     32'd0, 1'b0, 1'b1));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(9), DC,    1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0,     DC,    1'b0, 1'b0));

        // Reset at sweep index 10, then grant from pointer 0 (ptr was 1)
        scn_r = 8'd7;
        step(1'b1, 1'b1, 4'b0000, mk(4'b0000, 32'd0, DC, 1'b0, 1'b0));
        for (int k = 1; k < 10; k++) begin
            step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(k), 32'd0, 1'b1, 1'b0));
        end
        step(1'b0, 1'b0, 4'b0000, mk(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0));
        step(1'b0, 1'b0, 4'b1111, mk(4'b0000, 32'd0, 32'd0, 1'b0, 1'b0));
        set_req(0, 5'd7, DF);
        step(1'b1, 1'b0, 4'b1001, mk(4'b0001, 32'd0,     32'd0, 1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, bit_at(7), DF,    1'b0, 1'b0));
        step(1'b1, 1'b0, 4'b0000, mk(4'b0000, 32'd0,     DF,    1'b0, 1'b0));

        for (int i = 0; i < 8 && exp_q.size() != 0; i++) @(negedge clk);
        @(posedge clk);
        if (exp_q.size() != 0) begin
            tests_run++;
            tests_failed++;
            $display("FAIL drain: %0d expected records left, want 0", exp_q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
